timer_countdown: RTL and testbench
==================================

# timer_countdown

Datapath stage directly downstream of `TimerController`: holds the egg-timer value as two BCD digit pairs (minutes, seconds) and counts it down at a parameterised tick rate. It consumes the controller's `STATE` code and the setting switches, drives the 7-segment digit bus, and produces `finBit` back to the controller when the count expires.

## Interface

**Parameters**
- `TICK_CYCLES`, default 50_000_000: `CLK` cycles per countdown step (1 s at 50 MHz). Benches use 4.

**Ports**
- `CLK`, in, 1: single clock; all logic rises on posedge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `STATE`, in, 4: controller state code.
- `SW`, in, 8: set value, two BCD digits {tens, ones}.
- `MIN_BCD`, out, 8: minutes {tens, ones}, range 00–99.
- `SEC_BCD`, out, 8: seconds {tens, ones}, range 00–59.
- `finBit`, out, 1: countdown-expired flag.
- `TICK`, out, 1: one-cycle pulse on each countdown step.

## Operation

**STATE encoding (team-fixed)**
- 0000 IDLE, 0001 SET_SEC, 0010 SET_MIN, 0011 READY, 0100 RUN, 0101 PAUSE, 0110 DONE.
- Undefined codes behave as PAUSE: hold everything.

**Per-state behaviour**
- IDLE: MIN/SEC load 00:00; prescaler cleared; `finBit`=0.
- SET_SEC: `SEC_BCD` loads clamped `SW` every cycle. Clamp: tens>5 → value 59; else ones>9 → ones=9. `finBit`=0. Prescaler cleared.
- SET_MIN: `MIN_BCD` loads clamped `SW` every cycle. Clamp: each digit >9 → 9. `finBit`=0. Prescaler cleared.
- READY: hold value; prescaler cleared.
- RUN: prescaler counts 0..`TICK_CYCLES`-1. On the wrap cycle, `TICK`=1 and the value decrements by one second.
- PAUSE: hold value and prescaler phase. Resuming RUN continues from the same phase.
- DONE: hold 00:00; hold `finBit`.

**Decrement (BCD borrow chain)**
- sec ones>0: ones−1.
- else sec tens>0: tens−1, ones=9.
- else minutes≠00: sec=59, minutes decrement with the same digit borrow.
- 00:00 never decrements; no wrap to 99:59.

**finBit**
- Set when the value is 00:00 while STATE=RUN. This covers both a decrement reaching 00:00 and entering RUN already at 00:00.
- Sticky through RUN, PAUSE and DONE.
- Cleared only by `RESET`, IDLE, SET_SEC, or SET_MIN.
- While `finBit`=1, ticks are suppressed (`TICK` stays 0).

**Prescaler width**: $clog2(`TICK_CYCLES`), minimum 1 bit.

## Timing

**Reset**
- On `RESET`=1 (async), all outputs go to 0 immediately: `MIN_BCD`=00, `SEC_BCD`=00, `finBit`=0, `TICK`=0. Prescaler is cleared.
- Reset asserted mid-RUN discards the count.

**Latencies**
- `SW` → `MIN_BCD`/`SEC_BCD`: 1 cycle in the matching SET state.
- RUN entry → first `TICK`: exactly `TICK_CYCLES` cycles after the first RUN cycle. The prescaler starts at 0 in that cycle.
- `TICK` and the decremented value appear in the same cycle: `TICK` is registered alongside the value.
- Value reaching 00:00 → `finBit`=1 one cycle later. The compare is registered on the new value.
- Entering RUN at 00:00 → `finBit`=1 on the second RUN cycle; no `TICK` ever occurs.

**STATE changes and simultaneous events**
- STATE is sampled each cycle with no extra registering.
- A STATE change on the wrap cycle: the new state wins. RUN→PAUSE on the wrap cycle means no decrement, and the prescaler holds at `TICK_CYCLES`−1.
- Leaving RUN for READY/SET/IDLE clears the prescaler.

## Test plan

- **Reset mid-run:** `TICK_CYCLES`=4, load 01:30, RUN 10 cycles, pulse `RESET` → outputs 00:00, `finBit`=0 asynchronously, before the next edge.
- **Set with clamp:** SET_SEC with `SW`=8'h75 → `SEC_BCD`=59. SET_MIN with `SW`=8'h1A → `MIN_BCD`=19. `SW`=8'h42 in SET_SEC → 42, one cycle after apply.
- **Borrow chain:** load 01:00, RUN → after 4 cycles `TICK`=1 and value 00:59. Continue to 00:01, then 00:00; `finBit`=1 the following cycle. `TICK` never pulses again over 20 more cycles.
- **Pause phase hold:** load 00:05, RUN 2 cycles, PAUSE 10 cycles (value and `TICK` static), RUN → next `TICK` 2 cycles later and value 00:04.
- **Zero start:** load 00:00, READY→RUN → `finBit`=1 on RUN cycle 2, `TICK` stays 0. Then SET_SEC → `finBit`=0 the next cycle.
- **Wrap-cycle state change:** RUN, switch to PAUSE exactly on prescaler count 3 → no decrement. Return to RUN → `TICK` on the first RUN cycle.

Source files
------------

// File: rtl/timer_countdown.sv
// Egg-timer countdown datapath: holds MM:SS as BCD digit pairs, loads them from the
// setting switches, and counts down once per TICK_CYCLES clocks while the controller is in RUN.
module timer_countdown #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] STATE,
  input  logic [7:0] SW,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic       finBit,
  output logic       TICK
);

  localparam int unsigned PW = ($clog2(TICK_CYCLES) < 1) ? 1 : $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(TICK_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SET_SEC = 4'd1,
    ST_SET_MIN = 4'd2,
    ST_READY   = 4'd3,
    ST_RUN     = 4'd4,
    ST_PAUSE   = 4'd5,
    ST_DONE    = 4'd6
  } state_e;

  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          fin_q, fin_d;
  logic          tick_q, tick_d;
  logic          at_zero;

  // Seconds: an out-of-range tens digit saturates the whole pair to 59.
  function automatic logic [7:0] clamp_sec(input logic [7:0] v);
    if (v[7:4] > 4'd5)      return 8'h59;
    else if (v[3:0] > 4'd9) return {v[7:4], 4'd9};
    else                    return v;
  endfunction

  function automatic logic [7:0] clamp_min(input logic [7:0] v);
    return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
  endfunction

  assign at_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    min_d  = min_q;
    sec_d  = sec_q;
    cnt_d  = cnt_q;
    fin_d  = fin_q;
    tick_d = 1'b0;
    case (state_e'(STATE))
      ST_IDLE: begin
        min_d = 8'h00;
        sec_d = 8'h00;
        cnt_d = '0;
        fin_d = 1'b0;
      end
      ST_SET_SEC: begin
        sec_d = clamp_sec(SW);
        cnt_d = '0;
        fin_d = 1'b0;
      end
      ST_SET_MIN: begin
        min_d = clamp_min(SW);
        cnt_d = '0;
        fin_d = 1'b0;
      end
      ST_READY: cnt_d = '0;
      ST_RUN: begin
        // Expiry freezes the prescaler, so no tick can follow 00:00.
        if (at_zero) begin
          fin_d = 1'b1;
        end else if (!fin_q) begin
          if (cnt_q == LAST_PHASE) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (sec_q[3:0] != 4'd0) begin
              sec_d = sec_q - 8'd1;
            end else if (sec_q[7:4] != 4'd0) begin
              sec_d = {sec_q[7:4] - 4'd1, 4'd9};
            end else begin
              sec_d = 8'h59;
              min_d = (min_q[3:0] != 4'd0) ? (min_q - 8'd1) : {min_q[7:4] - 4'd1, 4'd9};
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ; // PAUSE, DONE and undefined codes hold everything
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      min_q  <= 8'h00;
      sec_q  <= 8'h00;
      cnt_q  <= '0;
      fin_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      sec_q  <= sec_d;
      cnt_q  <= cnt_d;
      fin_q  <= fin_d;
      tick_q <= tick_d;
    end
  end

  assign MIN_BCD = min_q;
  assign SEC_BCD = sec_q;
  assign finBit  = fin_q;
  assign TICK    = tick_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Self-checking bench for timer_countdown: constant vector table, hand-written corner
// sequences and randomized traffic, all compared against a seconds-count reference model.
module tb_timer_countdown;

  localparam int TC = 4;

  localparam logic [3:0] S_IDLE = 4'd0, S_SSEC = 4'd1, S_SMIN = 4'd2, S_READY = 4'd3,
                         S_RUN = 4'd4, S_PAUSE = 4'd5, S_DONE = 4'd6;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] STATE;
  logic [7:0] SW;
  logic [7:0] MIN_BCD, SEC_BCD;
  logic       finBit, TICK;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model: total remaining time in seconds plus the phase within a step.
  int m_total, m_phase;
  bit m_fin, m_tick;

  timer_countdown #(.TICK_CYCLES(TC)) dut (
    .CLK(CLK), .RESET(RESET), .STATE(STATE), .SW(SW),
    .MIN_BCD(MIN_BCD), .SEC_BCD(SEC_BCD), .finBit(finBit), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_total = 0; m_phase = 0; m_fin = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic [3:0] st, input logic [7:0] sw);
    int t, o, m;
    t = int'(sw[7:4]);
    o = int'(sw[3:0]);
    m_tick = 0;
    case (st)
      S_IDLE: begin m_total = 0; m_phase = 0; m_fin = 0; end
      S_SSEC: begin
        m_total = (m_total / 60) * 60 + ((t > 5) ? 59 : t * 10 + ((o > 9) ? 9 : o));
        m_phase = 0; m_fin = 0;
      end
      S_SMIN: begin
        m = ((t > 9) ? 9 : t) * 10 + ((o > 9) ? 9 : o);
        m_total = m * 60 + m_total % 60;
        m_phase = 0; m_fin = 0;
      end
      S_READY: m_phase = 0;
      S_RUN: begin
        if (m_total == 0) m_fin = 1;
        else if (!m_fin) begin
          if (m_phase == TC - 1) begin
            m_phase = 0; m_total--; m_tick = 1;
          end else m_phase++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    check("min", MIN_BCD, to_bcd(m_total / 60));
    check("sec", SEC_BCD, to_bcd(m_total % 60));
    check("fin", finBit, m_fin);
    check("tick", TICK, m_tick);
  endtask

  // One clock cycle: drive, clock, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] st, input logic [7:0] sw);
    STATE = st;
    SW    = sw;
    @(posedge CLK);
    model_step(st, sw);
    #1;
    compare_model();
  endtask

  task automatic load(input logic [7:0] mm, input logic [7:0] ss);
    step(S_IDLE, 8'h00);
    step(S_SMIN, mm);
    step(S_SSEC, ss);
    step(S_READY, 8'h00);
  endtask

  typedef struct {
    logic [3:0] st;
    logic [7:0] sw;
    logic [7:0] exp_min;
    logic [7:0] exp_sec;
    logic       exp_fin;
  } vec_t;

  vec_t vecs[10];
  int   n_ticks;

  initial begin
    vecs[0] = '{S_IDLE,  8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{S_SSEC,  8'h75, 8'h00, 8'h59, 1'b0};
    vecs[2] = '{S_SSEC,  8'h42, 8'h00, 8'h42, 1'b0};
    vecs[3] = '{S_SSEC,  8'h3C, 8'h00, 8'h39, 1'b0};
    vecs[4] = '{S_SSEC,  8'h9F, 8'h00, 8'h59, 1'b0};
    vecs[5] = '{S_SMIN,  8'h1A, 8'h19, 8'h59, 1'b0};
    vecs[6] = '{S_SMIN,  8'hAF, 8'h99, 8'h59, 1'b0};
    vecs[7] = '{S_SMIN,  8'h05, 8'h05, 8'h59, 1'b0};
    vecs[8] = '{S_READY, 8'h33, 8'h05, 8'h59, 1'b0};
    vecs[9] = '{S_IDLE,  8'h77, 8'h00, 8'h00, 1'b0};

    RESET = 1'b1; STATE = S_IDLE; SW = 8'h00;
    model_reset();
    #12;
    check("reset_min", MIN_BCD, 8'h00);
    check("reset_sec", SEC_BCD, 8'h00);
    check("reset_fin", finBit, 1'b0);
    check("reset_tick", TICK, 1'b0);
    RESET = 1'b0;

    // Load / clamp vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].st, vecs[i].sw);
      check($sformatf("vec%0d_min", i), MIN_BCD, vecs[i].exp_min);
      check($sformatf("vec%0d_sec", i), SEC_BCD, vecs[i].exp_sec);
      check($sformatf("vec%0d_fin", i), finBit, vecs[i].exp_fin);
    end

    // Borrow chain 01:00 -> 00:59 -> ... -> 00:00, then silence
    load(8'h01, 8'h00);
    repeat (3) step(S_RUN, 8'h00);
    check("borrow_no_early_tick", TICK, 1'b0);
    step(S_RUN, 8'h00);
    check("borrow_tick", TICK, 1'b1);
    check("borrow_min", MIN_BCD, 8'h00);
    check("borrow_sec", SEC_BCD, 8'h59);
    repeat (58 * TC) step(S_RUN, 8'h00);
    check("borrow_at_01", SEC_BCD, 8'h01);
    repeat (TC) step(S_RUN, 8'h00);
    check("borrow_at_00", SEC_BCD, 8'h00);
    check("borrow_fin_not_yet", finBit, 1'b0);
    step(S_RUN, 8'h00);
    check("borrow_fin_set", finBit, 1'b1);
    n_ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(S_RUN, 8'h00);
      n_ticks += int'(TICK);
    end
    check("borrow_no_more_ticks", n_ticks, 0);
    step(S_DONE, 8'h00);
    check("done_fin_sticky", finBit, 1'b1);

    // Pause keeps prescaler phase
    load(8'h00, 8'h05);
    repeat (2) step(S_RUN, 8'h00);
    repeat (10) step(S_PAUSE, 8'h00);
    check("pause_sec", SEC_BCD, 8'h05);
    step(S_RUN, 8'h00);
    check("pause_resume_no_tick", TICK, 1'b0);
    step(S_RUN, 8'h00);
    check("pause_resume_tick", TICK, 1'b1);
    check("pause_resume_sec", SEC_BCD, 8'h04);

    // Zero start: expires without ever ticking, cleared by SET_SEC
    load(8'h00, 8'h00);
    check("zero_fin_before", finBit, 1'b0);
    step(S_RUN, 8'h00);
    check("zero_fin_run2", finBit, 1'b1);
    check("zero_no_tick", TICK, 1'b0);
    step(S_SSEC, 8'h00);
    check("zero_fin_cleared", finBit, 1'b0);

    // PAUSE on the wrap cycle: no decrement, tick right after resuming
    load(8'h00, 8'h10);
    repeat (3) step(S_RUN, 8'h00);
    step(S_PAUSE, 8'h00);
    check("wrap_pause_no_tick", TICK, 1'b0);
    check("wrap_pause_sec", SEC_BCD, 8'h10);
    step(S_PAUSE, 8'h00);
    step(S_RUN, 8'h00);
    check("wrap_resume_tick", TICK, 1'b1);
    check("wrap_resume_sec", SEC_BCD, 8'h09);

    // Asynchronous reset mid-run
    load(8'h01, 8'h30);
    repeat (10) step(S_RUN, 8'h00);
    #2 RESET = 1'b1;
    #1;
    check("async_rst_min", MIN_BCD, 8'h00);
    check("async_rst_sec", SEC_BCD, 8'h00);
    check("async_rst_fin", finBit, 1'b0);
    check("async_rst_tick", TICK, 1'b0);
    #2 RESET = 1'b0;
    model_reset();
    step(S_RUN, 8'h00);

    // Randomized traffic, biased toward RUN so countdowns make progress
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] st;
      if ($urandom_range(0, 9) < 6) st = S_RUN;
      else st = 4'($urandom_range(0, 15));
      step(st, 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
